// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, one bit per cycle, LSB first
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             accept;
    logic             last;
    logic             d;
    logic             br_next;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    // Next-state decode plus the per-bit subtract of the current LSBs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        d          = a_sr[0] ^ b_sr[0] ^ br;
        br_next    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_BIT) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, shifting datapath and result registers; busy/done are
    // registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            busy_q <= (state_next == RUN);
            done_q <= (state_next == DONE);
            if (accept) begin
                a_sr  <= bus.a;
                b_sr  <= bus.b;
                br    <= bus.bin;
                cnt   <= '0;
                a_msb <= bus.a[WIDTH-1];
                b_msb <= bus.b[WIDTH-1];
            end else if (state == RUN) begin
                a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                res_sr <= {d, res_sr[WIDTH-1:1]};
                br     <= br_next;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    // Last bit goes straight into the MSB of the published result.
                    diff_q <= {d, res_sr[WIDTH-1:1]};
                    bout_q <= br_next;
                    ovf_q  <= (a_msb != b_msb) && (d != a_msb);
                end
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and randomized bench for serial_subtractor
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation from IDLE and count edges from accept to done.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = bi;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        bus.bin   = 1'($urandom);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++;
        if (bus.diff !== 8'h00) begin errors++; $display("FAIL reset_diff got %h want 00", bus.diff); end
        checks++;
        if ({bus.bout, bus.ovf} !== 2'b00) begin
            errors++; $display("FAIL reset_flags got %b want 00", {bus.bout, bus.ovf});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        run_op(8'h5A, 8'h3C, 1'b0, lat);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
        checks++;
        if ({bus.diff, bus.bout, bus.ovf} !== {8'h1E, 1'b0, 1'b0}) begin
            errors++; $display("FAIL basic_result got %h/%b/%b want 1e/0/0", bus.diff, bus.bout, bus.ovf);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", bus.busy); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", bus.done); end
        checks++;
        if (bus.diff !== 8'h1E) begin errors++; $display("FAIL basic_hold got %h want 1e", bus.diff); end
    endtask

    task automatic test_borrow();
        int lat;
        run_op(8'h00, 8'h01, 1'b0, lat);
        checks++;
        if ({bus.diff, bus.bout, bus.ovf} !== {8'hFF, 1'b1, 1'b0} || lat !== 8) begin
            errors++; $display("FAIL borrow_0_1 got %h/%b/%b lat %0d want ff/1/0 lat 8", bus.diff, bus.bout, bus.ovf, lat);
        end
        run_op(8'h10, 8'h10, 1'b1, lat);
        checks++;
        if ({bus.diff, bus.bout, bus.ovf} !== {8'hFF, 1'b1, 1'b0} || lat !== 8) begin
            errors++; $display("FAIL borrow_bin got %h/%b/%b lat %0d want ff/1/0 lat 8", bus.diff, bus.bout, bus.ovf, lat);
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_op(8'h80, 8'h01, 1'b0, lat);
        checks++;
        if ({bus.diff, bus.bout, bus.ovf} !== {8'h7F, 1'b0, 1'b1} || lat !== 8) begin
            errors++; $display("FAIL ovf_neg got %h/%b/%b lat %0d want 7f/0/1 lat 8", bus.diff, bus.bout, bus.ovf, lat);
        end
        run_op(8'h7F, 8'hFF, 1'b0, lat);
        checks++;
        if ({bus.diff, bus.bout, bus.ovf} !== {8'h80, 1'b1, 1'b1} || lat !== 8) begin
            errors++; $display("FAIL ovf_pos got %h/%b/%b lat %0d want 80/1/1 lat 8", bus.diff, bus.bout, bus.ovf, lat);
        end
    endtask

    task automatic test_start_ignored();
        int pulses;
        logic [7:0] got;
        pulses = 0;
        got    = 8'h00;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h3C; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.bin = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                pulses++;
                got = bus.diff;
            end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
        checks++;
        if (got !== 8'h1E) begin errors++; $display("FAIL ignore_result got %h want 1e", got); end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        int lat;
        pulses = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h3C; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.bout, bus.ovf} !== 12'h000) begin
            errors++; $display("FAIL midrun_async_clear got busy %b done %b diff %h bout %b ovf %b want all 0",
                               bus.busy, bus.done, bus.diff, bus.bout, bus.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL midrun_no_done got %0d want 0", pulses); end
        checks++;
        if (bus.diff !== 8'h00) begin errors++; $display("FAIL midrun_diff_after got %h want 00", bus.diff); end
        run_op(8'h03, 8'h01, 1'b0, lat);
        checks++;
        if (bus.diff !== 8'h02 || lat !== 8) begin
            errors++; $display("FAIL midrun_recover got %h lat %0d want 02 lat 8", bus.diff, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] op_a [3];
        logic [7:0] op_b [3];
        logic [7:0] exp_d [3];
        int k;
        int cyc;
        int prev;
        op_a[0] = 8'h5A; op_b[0] = 8'h3C; exp_d[0] = 8'h1E;
        op_a[1] = 8'h00; op_b[1] = 8'h01; exp_d[1] = 8'hFF;
        op_a[2] = 8'h80; op_b[2] = 8'h01; exp_d[2] = 8'h7F;
        k    = 0;
        cyc  = 0;
        prev = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = op_a[0]; bus.b = op_b[0]; bus.bin = 1'b0;
        while (k < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                checks++;
                if (bus.diff !== exp_d[k]) begin
                    errors++; $display("FAIL b2b_result_%0d got %h want %h", k, bus.diff, exp_d[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (cyc - prev !== 10) begin
                        errors++; $display("FAIL b2b_spacing_%0d got %0d want 10", k, cyc - prev);
                    end
                end
                prev = cyc;
                k++;
                if (k < 3) begin
                    bus.a = op_a[k];
                    bus.b = op_b[k];
                end else begin
                    bus.start = 1'b0;
                end
            end else if (k > 0) begin
                checks++;
                if (bus.diff !== exp_d[k-1]) begin
                    errors++; $display("FAIL b2b_stable_%0d got %h want %h", k, bus.diff, exp_d[k-1]);
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (k !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", k); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int lat;
        int r;
        int s;
        logic [7:0] av;
        logic [7:0] bv;
        logic bi;
        logic [7:0] exp_diff;
        logic exp_bout;
        logic exp_ovf;
        for (int n = 0; n < 1000; n++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            bi = 1'($urandom);
            r = int'(av) - int'(bv) - int'(bi);
            s = int'($signed(av)) - int'($signed(bv)) - int'(bi);
            exp_diff = r[7:0];
            exp_bout = (r < 0);
            exp_ovf  = (s > 127) || (s < -128);
            run_op(av, bv, bi, lat);
            checks++;
            if ({bus.diff, bus.bout, bus.ovf} !== {exp_diff, exp_bout, exp_ovf} || lat !== 8) begin
                errors++;
                $display("FAIL rand_%0d %h-%h-%b got %h/%b/%b lat %0d want %h/%b/%b lat 8",
                         n, av, bv, bi, bus.diff, bus.bout, bus.ovf, lat, exp_diff, exp_bout, exp_ovf);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end
endmodule
